cpu54_divider: RTL and testbench
================================

Name: cpu54_divider

Overview:
Iterative 32-bit integer divider for the CPU54 core that executes DIV and DIVU. It consumes the two operands read from the register file (rs = dividend, rt = divisor) and produces quotient and remainder for the HI/LO write path (LO = quotient, HI = remainder). It runs as a multi-cycle unit. The control unit stalls on busy and captures results on done.

Parameters:
WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.

Ports:
clock_in      input   1      system clock; all state updates on the rising edge.
reset_signal  input   1      reset, synchronous, active-low.
start         input   1      request a division; sampled only when the unit is not busy.
is_signed     input   1      1 = DIV (two's complement), 0 = DIVU.
dividend      input   WIDTH  rs operand from the register file.
divisor       input   WIDTH  rt operand from the register file.
quotient      output  WIDTH  result for LO; held until the next accepted start.
remainder     output  WIDTH  result for HI; held until the next accepted start.
busy          output  1      high while an operation is in progress.
done          output  1      one-cycle pulse; results are valid in this cycle.
div_by_zero   output  1      high with done when the divisor was 0; held with the results.

Behaviour:
- Reset: reset_signal sampled low at a rising edge puts the unit in IDLE and clears quotient, remainder, busy, done and div_by_zero to 0. Reset overrides everything, including an operation in progress. The aborted operation leaves no trace.
- States:
  - IDLE: start=1 latches |dividend|, |divisor|, the sign of each operand (only when is_signed=1; otherwise both signs are 0), and a zero-divisor flag; clears the iteration counter; goes to RUN.
  - RUN: performs one restoring step per cycle, MSB first. Each step shifts {partial remainder, dividend bit} left, trial-subtracts the divisor, and keeps the difference plus a quotient bit of 1 if there is no borrow. After WIDTH steps it goes to DONE.
  - DONE: done=1 for exactly one cycle. Behaves as IDLE for start acceptance, so start=1 here begins a new operation (back-to-back operation).
- Timing: if start is accepted at edge 0, busy is high from edge 0 to edge WIDTH. Results and done are registered at edge WIDTH, so done is high in the cycle after edge WIDTH. Total latency is WIDTH+1 cycles from start to done, independent of operand values.
- start while busy=1 is ignored. Operand inputs are don't-care after the accepting edge.
- Sign fix-up, applied at the final edge:
  - quotient is negated if sign(dividend) XOR sign(divisor);
  - remainder is negated if sign(dividend);
  - absolute values use unsigned WIDTH-bit negation.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) must yield quotient 0x80000000 and remainder 0. This falls out of unsigned magnitude arithmetic and needs no special case.
- Divisor 0: still runs the full WIDTH+1 latency. Results are quotient = all ones and remainder = original dividend (unsigned bit pattern, no fix-up). div_by_zero=1.
- quotient, remainder and div_by_zero change only at the DONE-producing edge or on reset.

Decomposition:
- Shared package cpu54_div_pkg holds:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - WIDTH default;
  - iteration counter width, $clog2(WIDTH)+1.
- One natural sub-module: cpu54_div_step. It is purely combinational and performs a single restoring step. Inputs: partial remainder, incoming dividend bit, divisor. Outputs: next partial remainder, quotient bit. It is instantiated once inside the RUN datapath.

Test Plan:
- Unsigned basic: is_signed=0, 7/2 -> after 33 cycles done=1, quotient=0x00000003, remainder=0x00000001, div_by_zero=0. busy must be high for exactly 32 cycles.
- Signed negatives: is_signed=1, 0xFFFFFFF9/0x00000002 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also -7/-2 -> quotient=0x00000003, remainder=0xFFFFFFFF.
- Overflow and large unsigned: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/0x00000010 -> quotient=0x0FFFFFFF, remainder=0x0000000F.
- Divide by zero: 5/0 -> quotient=0xFFFFFFFF, remainder=0x00000005, div_by_zero=1, same 33-cycle latency.
- Handshake: start pulsed again at cycles 5 and 20 of an operation -> ignored, first result unchanged. start held during the DONE cycle -> a second operation begins, with its done exactly 33 cycles later.
- Reset mid-operation: reset_signal low at cycle 10 of RUN -> next cycle busy=0, done=0, quotient=0, remainder=0. A following 100/7 gives quotient=14, remainder=2.

Source files
------------

// File: rtl/cpu54_div_pkg.sv
// Shared definitions for the CPU54 iterative divider: state encoding,
// default operand width and iteration counter sizing.
package cpu54_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef logic [1:0] div_state_t;

    localparam div_state_t IDLE = 2'd0;
    localparam div_state_t RUN  = 2'd1;
    localparam div_state_t DONE = 2'd2;

    // One spare bit so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/cpu54_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not borrow.
module cpu54_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted = {rem_in, bit_in};

    // No borrow exactly when the shifted remainder is at least the divisor;
    // the kept difference is then below the divisor, so the low bits suffice.
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign rem_out = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/cpu54_divider.sv
// Iterative DIV/DIVU unit: one restoring step per cycle on operand magnitudes,
// sign fix-up applied when the last step is registered into the results.
module cpu54_divider
    import cpu54_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock_in,
    input  logic             reset_signal,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t state, state_next;

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dq_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt_r;
    logic             neg_dd_r;
    logic             neg_dv_r;
    logic             dz_r;

    logic             accept;
    logic             last_step;
    logic             dd_neg;
    logic             dv_neg;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quo_mag;

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt_r == CW'(WIDTH - 1));

    assign dd_neg = is_signed & dividend[WIDTH-1];
    assign dv_neg = is_signed & divisor[WIDTH-1];
    assign dd_mag = dd_neg ? -dividend : dividend;
    assign dv_mag = dv_neg ? -divisor  : divisor;

    cpu54_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_r),
        .bit_in  (dq_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Dividend bits shift out of the top of dq_r as quotient bits shift in.
    assign quo_mag = {dq_r[WIDTH-2:0], step_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of the order of statements.
    always_ff @(posedge clock_in) begin
        if (!reset_signal) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        state_next = last_step ? DONE : RUN;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: the working datapath has no reset; it is always reloaded on an
    // accepted start, and only the visible results must be cleared by reset.
    always_ff @(posedge clock_in) begin
        if (accept) begin
            rem_r    <= '0;
            dq_r     <= dd_mag;
            dvs_r    <= dv_mag;
            cnt_r    <= '0;
            neg_dd_r <= dd_neg;
            neg_dv_r <= dv_neg;
            dz_r     <= (divisor == '0);
        end else if (state == RUN) begin
            rem_r <= step_rem;
            dq_r  <= quo_mag;
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // A zero divisor leaves |dividend| as the remainder magnitude, so the
    // usual remainder fix-up restores the original dividend bit pattern.
    always_ff @(posedge clock_in) begin
        if (!reset_signal) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (last_step) begin
            if (dz_r) begin
                quotient <= '1;
            end else begin
                quotient <= (neg_dd_r ^ neg_dv_r) ? -quo_mag : quo_mag;
            end
            remainder   <= neg_dd_r ? -step_rem : step_rem;
            div_by_zero <= dz_r;
        end
    end

endmodule

// File: tb/tb_cpu54_divider.sv
// Self-checking bench for cpu54_divider: directed vector table, handshake and
// reset sequences, and randomized operations against an arithmetic model.
module tb_cpu54_divider;

    logic        clock_in;
    logic        reset_signal;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    cpu54_divider #(
        .WIDTH (32)
    ) dut (
        .clock_in     (clock_in),
        .reset_signal (reset_signal),
        .start        (start),
        .is_signed    (is_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .quotient     (quotient),
        .remainder    (remainder),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        logic        sg;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic; SV division truncates toward zero and the
    // remainder takes the dividend's sign, matching DIV semantics.
    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t   res;
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            res.q  = 32'hFFFF_FFFF;
            res.r  = a;
            res.dz = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = {32'h0, a};
                sb = {32'h0, b};
            end
            res.q  = 32'(sa / sb);
            res.r  = 32'(sa % sb);
            res.dz = 1'b0;
        end
        return res;
    endfunction

    // Called just after a falling edge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] dd, input logic [31:0] dv, input logic sg);
        dividend  = dd;
        divisor   = dv;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clock_in);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Counts falling edges until done; lat = 0 means the budget expired.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock_in);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                                 input logic sg, input res_t exp);
        int lat;
        int bc;
        issue(dd, dv, sg);
        wait_done(lat, bc);
        check({tag, " latency"}, 32'(lat), 32'd33);
        check({tag, " busy_cycles"}, 32'(bc), 32'd32);
        check({tag, " quotient"}, quotient, exp.q);
        check({tag, " remainder"}, remainder, exp.r);
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp.dz));
    endtask

    vec_t vecs[$];

    initial begin
        res_t exp;
        res_t held;
        int   lat;
        int   bc;
        int   spurious;

        vecs.push_back('{32'd7,          32'd2,          1'b0, 32'h0000_0003, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'h0000_0010,  1'b0, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC, 32'h0000_0001, 1'b0});
        vecs.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1});
        vecs.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,        32'd2,         1'b0});
        vecs.push_back('{32'd3,          32'd9,          1'b1, 32'd0,         32'd3,         1'b0});

        reset_signal = 1'b0;
        start        = 1'b0;
        is_signed    = 1'b0;
        dividend     = '0;
        divisor      = '0;
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        reset_signal = 1'b1;
        @(negedge clock_in);

        // Directed table; after each result, confirm done is a single pulse
        // and the results hold while idle.
        foreach (vecs[i]) begin
            exp.q  = vecs[i].exp_q;
            exp.r  = vecs[i].exp_r;
            exp.dz = vecs[i].exp_dz;
            run_and_check($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].sg, exp);
            @(negedge clock_in);
            check($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d hold_q", i), quotient, vecs[i].exp_q);
        end

        // Extra starts at cycles 5 and 20 of a running operation are ignored.
        issue(32'd100, 32'd7, 1'b0);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock_in);
            if (k == 5 || k == 20) begin
                start     = 1'b1;
                dividend  = $urandom;
                divisor   = $urandom | 32'd1;
                is_signed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check("ignored_start latency", 32'(lat), 32'd33);
        check("ignored_start quotient", quotient, 32'd14);
        check("ignored_start remainder", remainder, 32'd2);
        @(negedge clock_in);
        check("ignored_start no_relaunch", 32'(busy), 32'd0);

        // Back-to-back: start held in the DONE cycle launches the next op.
        issue(32'd1000, 32'd3, 1'b0);
        wait_done(lat, bc);
        check("b2b first quotient", quotient, 32'd333);
        check("b2b first remainder", remainder, 32'd1);
        issue(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_done(lat, bc);
        check("b2b second latency", 32'(lat), 32'd33);
        check("b2b second quotient", quotient, 32'hFFFF_FFF2);
        check("b2b second remainder", remainder, 32'hFFFF_FFFE);

        // Reset in the middle of RUN aborts with no trace.
        @(negedge clock_in);
        issue(32'hFFFF_0000, 32'd3, 1'b0);
        repeat (10) @(negedge clock_in);
        reset_signal = 1'b0;
        @(negedge clock_in);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        check("midreset div_by_zero", 32'(div_by_zero), 32'd0);
        reset_signal = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clock_in);
            if (done || busy) spurious++;
        end
        check("midreset no_late_done", 32'(spurious), 32'd0);
        exp = ref_div(32'd100, 32'd7, 1'b0);
        run_and_check("after_reset", 32'd100, 32'd7, 1'b0, exp);

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s);
            run_and_check($sformatf("rand%0d", n), a, b, s, exp);
            if (n % 4 == 0) begin
                held = exp;
                repeat (3) @(negedge clock_in);
                check($sformatf("rand%0d hold_r", n), remainder, held.r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
